// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - LC-3b instruction fetch stage: PC, imem read handshake, one-word buffer.
// Optional memory-wait counter on stall_cnt when FETCH_PERF_CNT_EN is defined.
module fetch_stage #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic        imem_read,
  output logic [15:0] imem_address,
  input  logic        imem_resp,
  input  logic [15:0] imem_rdata,
  output logic [15:0] pc_out,
  output logic [15:0] instr_out,
  output logic        advance
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [15:0] stall_cnt
`endif
);

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    HOLD   = 2'd1,
    SQUASH = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] tgt_q, tgt_d;
  logic [15:0] pc_out_q, pc_out_d;
  logic [15:0] instr_out_q, instr_out_d;
  logic [15:0] redirect_tgt;
  logic [15:0] pc_inc;
  logic        busy;

  assign redirect_tgt = redirect_pc & 16'hFFFE;
  assign pc_inc       = pc_q + 16'd2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= FETCH;
      pc_q        <= RESET_PC;
      tgt_q       <= 16'h0000;
      pc_out_q    <= 16'h0000;
      instr_out_q <= 16'h0000;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      tgt_q       <= tgt_d;
      pc_out_q    <= pc_out_d;
      instr_out_q <= instr_out_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    tgt_d       = tgt_q;
    pc_out_d    = pc_out_q;
    instr_out_d = instr_out_q;
    busy        = 1'b0;
    advance     = 1'b0;
    case (state_q)
      FETCH: begin
        busy = 1'b1;
        if (imem_resp) begin
          if (redirect) begin
            pc_d = redirect_tgt;
          end else begin
            instr_out_d = imem_rdata;
            pc_out_d    = pc_inc;
            pc_d        = pc_inc;
            state_d     = HOLD;
          end
        end else if (redirect) begin
          // Address must stay stable until the in-flight read returns.
          tgt_d   = redirect_tgt;
          state_d = SQUASH;
        end
      end
      SQUASH: begin
        busy = 1'b1;
        if (redirect) tgt_d = redirect_tgt;
        if (imem_resp) begin
          pc_d    = redirect ? redirect_tgt : tgt_q;
          state_d = FETCH;
        end
      end
      HOLD: begin
        advance = !stall && !redirect;
        if (redirect) begin
          pc_d    = redirect_tgt;
          state_d = FETCH;
        end else if (!stall) begin
          state_d = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  // Reset forces the state to FETCH, so the request is gated off directly by rst_n.
  assign imem_read    = busy && rst_n;
  assign imem_address = pc_q;
  assign pc_out       = pc_out_q;
  assign instr_out    = instr_out_q;

`ifdef FETCH_PERF_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_cnt_q <= 16'h0000;
    else        stall_cnt_q <= stall_cnt_d;
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (imem_read && !imem_resp && (stall_cnt_q != 16'hFFFF))
      stall_cnt_d = stall_cnt_q + 16'd1;
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule
